// File: rtl/uart_msg_tx_if.sv
// Message-level port bundle of the UART message transmitter.
// The slave side is the transmitter; the master side is its user.
interface uart_msg_tx_if #(
  parameter int MSG_LEN = 4
);
  localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  logic                 start;
  logic [MSG_LEN*8-1:0] msg;
  logic                 tx;
  logic                 busy;
  logic                 done;
  logic [IDX_W-1:0]     char_idx;

  modport master (
    output start, msg,
    input  tx, busy, done, char_idx
  );

  modport slave (
    input  start, msg,
    output tx, busy, done, char_idx
  );
endinterface

// File: rtl/uart_msg_tx.sv
// Serialises a latched MSG_LEN-character message onto tx, character 0 first,
// with configurable data bits, parity, stop bits, idle gap and optional repeat.
module uart_msg_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MSG_LEN      = 4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int IDLE_BITS    = 1,
  parameter int REPEAT       = 0
) (
  input  logic          clk_50M,
  input  logic          rst,
  uart_msg_tx_if.slave  bus
);

  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int IDX_W    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int MAX_BITS = (IDLE_BITS > DATA_BITS)
                          ? ((IDLE_BITS > STOP_BITS) ? IDLE_BITS : STOP_BITS)
                          : ((DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS);
  localparam int BIT_W    = $clog2(MAX_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] GAP_LAST  = BIT_W'(IDLE_BITS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  // With no idle gap configured, each character starts directly with its start bit.
  localparam state_t FIRST_ST = (IDLE_BITS == 0) ? S_START : S_GAP;

  state_t               r_state;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [IDX_W-1:0]     r_char_idx;
  logic [MSG_LEN*8-1:0] r_buf;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;

  state_t               w_state_nxt;
  logic [CNT_W-1:0]     w_clk_nxt;
  logic [BIT_W-1:0]     w_bit_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic                 w_tx_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic [7:0]           w_char;
  logic                 w_bit_end;
  logic                 w_last_char;
  logic                 w_frame_end;

  assign w_bit_end   = (r_clk_cnt == CNT_LAST);
  assign w_last_char = (r_char_idx == IDX_LAST);
  assign w_frame_end = (r_state == S_STOP) && w_bit_end && (r_bit_cnt == STOP_LAST);

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_char_idx <= '0;
      r_buf      <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clk_cnt  <= w_clk_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_char_idx <= w_idx_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      if (r_state == S_IDLE && bus.start) begin
        r_buf <= bus.msg;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_char_idx;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = FIRST_ST;
          w_idx_nxt   = '0;
        end
      end
      S_GAP: begin
        if (w_bit_end && r_bit_cnt == GAP_LAST) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end && r_bit_cnt == DATA_LAST) begin
          w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (w_bit_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_frame_end) begin
          if (!w_last_char) begin
            w_state_nxt = FIRST_ST;
            w_idx_nxt   = r_char_idx + IDX_W'(1);
          end else begin
            w_state_nxt = (REPEAT != 0) ? FIRST_ST : S_IDLE;
            w_idx_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase

    w_clk_nxt = (r_state == S_IDLE || w_bit_end) ? '0 : r_clk_cnt + CNT_W'(1);

    // Bit counter restarts on every state change so each state counts its own bits.
    if (w_state_nxt != r_state) begin
      w_bit_nxt = '0;
    end else if (w_bit_end) begin
      w_bit_nxt = r_bit_cnt + BIT_W'(1);
    end else begin
      w_bit_nxt = r_bit_cnt;
    end
  end

  always_comb begin
    w_char     = r_buf[{w_idx_nxt, 3'b000} +: 8];
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = w_frame_end && w_last_char;
    // tx is computed from the next state, so the register changes only on bit boundaries.
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_char[w_bit_nxt[2:0]];
      S_PAR:   w_tx_nxt = (PARITY == 2) ? ~(^w_char[DATA_BITS-1:0]) : (^w_char[DATA_BITS-1:0]);
      default: w_tx_nxt = 1'b1;
    endcase
  end

  assign bus.tx       = r_tx;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.char_idx = r_char_idx;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Scoreboard bench: five transmitter configurations at 4 clocks per bit; stimulus
// pushes expected bits and done times, a negedge monitor pops and compares them.
module tb_uart_msg_tx;
  localparam int CPB = 4;
  localparam int NI  = 5;

  logic clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  logic rst_v [NI];

  uart_msg_tx_if #(.MSG_LEN(4)) if0 ();
  uart_msg_tx_if #(.MSG_LEN(1)) if1 ();
  uart_msg_tx_if #(.MSG_LEN(1)) if2 ();
  uart_msg_tx_if #(.MSG_LEN(1)) if3 ();
  uart_msg_tx_if #(.MSG_LEN(2)) if4 ();

  uart_msg_tx #(.CLKS_PER_BIT(CPB), .MSG_LEN(4)) u0 (
    .clk_50M(clk_50M), .rst(rst_v[0]), .bus(if0));
  uart_msg_tx #(.CLKS_PER_BIT(CPB), .MSG_LEN(1), .PARITY(1)) u1 (
    .clk_50M(clk_50M), .rst(rst_v[1]), .bus(if1));
  uart_msg_tx #(.CLKS_PER_BIT(CPB), .MSG_LEN(1), .PARITY(2)) u2 (
    .clk_50M(clk_50M), .rst(rst_v[2]), .bus(if2));
  uart_msg_tx #(.CLKS_PER_BIT(CPB), .MSG_LEN(1), .DATA_BITS(7), .STOP_BITS(2)) u3 (
    .clk_50M(clk_50M), .rst(rst_v[3]), .bus(if3));
  uart_msg_tx #(.CLKS_PER_BIT(CPB), .MSG_LEN(2), .REPEAT(1)) u4 (
    .clk_50M(clk_50M), .rst(rst_v[4]), .bus(if4));

  logic       tx_w   [NI];
  logic       busy_w [NI];
  logic       done_w [NI];
  logic [1:0] idx_w  [NI];

  assign tx_w[0] = if0.tx;  assign busy_w[0] = if0.busy;  assign done_w[0] = if0.done;
  assign tx_w[1] = if1.tx;  assign busy_w[1] = if1.busy;  assign done_w[1] = if1.done;
  assign tx_w[2] = if2.tx;  assign busy_w[2] = if2.busy;  assign done_w[2] = if2.done;
  assign tx_w[3] = if3.tx;  assign busy_w[3] = if3.busy;  assign done_w[3] = if3.done;
  assign tx_w[4] = if4.tx;  assign busy_w[4] = if4.busy;  assign done_w[4] = if4.done;
  assign idx_w[0] = if0.char_idx;
  assign idx_w[1] = {1'b0, if1.char_idx};
  assign idx_w[2] = {1'b0, if2.char_idx};
  assign idx_w[3] = {1'b0, if3.char_idx};
  assign idx_w[4] = {1'b0, if4.char_idx};

  int n_tests = 0;
  int n_fail  = 0;

  // Expected bit entries are encoded as char_idx*2 + tx.
  int   exp_q  [NI][$];
  int   done_q [NI][$];
  int   cyc    [NI];
  logic busy_p [NI];
  bit   rep    [NI] = '{0, 0, 0, 0, 1};

  function automatic void check(string name, int inst, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0d, expected %0d at %0t", name, inst, act, exp, $time);
    end
  endfunction

  function automatic void push_frame(int inst, logic [7:0] ch, int db, bit has_par,
                                     bit par_bit, int nstop, int idx, int upto);
    bit bits[$];
    bits.push_back(1'b1);
    bits.push_back(1'b0);
    for (int d = 0; d < db; d++) bits.push_back(ch[d]);
    if (has_par) bits.push_back(par_bit);
    for (int s = 0; s < nstop; s++) bits.push_back(1'b1);
    for (int k = 0; k < bits.size() && k < upto; k++) begin
      exp_q[inst].push_back(idx * 2 + int'(bits[k]));
    end
  endfunction

  function automatic void push_msg4(logic [31:0] m);
    for (int k = 0; k < 4; k++) push_frame(0, m[8*k +: 8], 8, 1'b0, 1'b0, 1, k, 99);
  endfunction

  always @(negedge clk_50M) begin
    for (int i = 0; i < NI; i++) begin
      if (busy_w[i] && !busy_p[i]) cyc[i] = 0;
      else cyc[i]++;
      busy_p[i] = busy_w[i];
      if (busy_w[i] && (cyc[i] % CPB) == 2) begin
        if (exp_q[i].size() > 0) begin
          int e;
          e = exp_q[i].pop_front();
          check($sformatf("tx_bit%0d", cyc[i] / CPB), i, int'(tx_w[i]), e % 2);
          check("char_idx", i, int'(idx_w[i]), e / 2);
        end else if (!rep[i]) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_bit inst%0d: got tx=%0d, expected no activity", i, tx_w[i]);
        end
      end
      if (done_w[i]) begin
        if (done_q[i].size() > 0) begin
          int e;
          e = done_q[i].pop_front();
          check("done_cycle", i, cyc[i], e);
          check("busy_at_done", i, int'(busy_w[i]), int'(rep[i]));
        end else begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done inst%0d: got done=1 at cycle %0d, expected none", i, cyc[i]);
        end
      end
    end
  end

  task automatic wait_done(int i, int budget);
    int k = 0;
    do begin
      @(negedge clk_50M);
      k++;
    end while (!done_w[i] && k < budget);
    n_tests++;
    if (!done_w[i]) begin
      n_fail++;
      $display("FAIL done_timeout inst%0d: got no done, expected one within %0d cycles", i, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_v[i]  = 1'b1;
      cyc[i]    = 0;
      busy_p[i] = 1'b0;
    end
    if0.start = 1'b0; if0.msg = '0;
    if1.start = 1'b0; if1.msg = '0;
    if2.start = 1'b0; if2.msg = '0;
    if3.start = 1'b0; if3.msg = '0;
    if4.start = 1'b0; if4.msg = '0;
    // start held high during reset must be overridden
    if0.start = 1'b1;
    repeat (3) @(posedge clk_50M);
    #1;
    for (int i = 0; i < NI; i++) begin
      check("rst_tx", i, int'(tx_w[i]), 1);
      check("rst_busy", i, int'(busy_w[i]), 0);
      check("rst_done", i, int'(done_w[i]), 0);
      check("rst_idx", i, int'(idx_w[i]), 0);
    end
    if0.start = 1'b0;
    for (int i = 0; i < NI; i++) rst_v[i] = 1'b0;

    fork
      begin
        // "7","3","B","S" with char0 = "S"; mid-message start and msg change ignored
        @(negedge clk_50M);
        if0.msg = 32'h3733_4253; if0.start = 1'b1;
        push_msg4(32'h3733_4253);
        done_q[0].push_back(176);
        @(posedge clk_50M); #1 if0.start = 1'b0;
        repeat (40) @(negedge clk_50M);
        if0.start = 1'b1; if0.msg = 32'hFFFF_FFFF;
        @(negedge clk_50M);
        if0.start = 1'b0;
        wait_done(0, 300);
        repeat (5) @(negedge clk_50M);
        // back-to-back: start held high across completion
        if0.msg = 32'h7E00_5AA5; if0.start = 1'b1;
        push_msg4(32'h7E00_5AA5);
        done_q[0].push_back(176);
        wait_done(0, 300);
        if0.msg = 32'h3733_4253;
        push_msg4(32'h3733_4253);
        done_q[0].push_back(176);
        @(posedge clk_50M); #1 if0.start = 1'b0;
        wait_done(0, 300);
        repeat (5) @(negedge clk_50M);
        // reset during data bit 3 of char 1 (global bit 16, cycles 64..67)
        if0.msg = 32'h3733_4253; if0.start = 1'b1;
        push_frame(0, 8'h53, 8, 1'b0, 1'b0, 1, 0, 99);
        push_frame(0, 8'h42, 8, 1'b0, 1'b0, 1, 1, 5);
        @(posedge clk_50M); #1 if0.start = 1'b0;
        repeat (65) @(posedge clk_50M);
        #1 rst_v[0] = 1'b1;
        @(posedge clk_50M);
        #1;
        check("midrst_tx", 0, int'(if0.tx), 1);
        check("midrst_busy", 0, int'(if0.busy), 0);
        check("midrst_idx", 0, int'(if0.char_idx), 0);
        check("midrst_done", 0, int'(if0.done), 0);
        rst_v[0] = 1'b0;
        @(negedge clk_50M);
        if0.start = 1'b1;
        push_msg4(32'h3733_4253);
        done_q[0].push_back(176);
        @(posedge clk_50M); #1 if0.start = 1'b0;
        wait_done(0, 300);
      end
      begin
        // even parity of 0x53 is 0
        @(negedge clk_50M);
        if1.msg = 8'h53; if1.start = 1'b1;
        push_frame(1, 8'h53, 8, 1'b1, 1'b0, 1, 0, 99);
        done_q[1].push_back(48);
        @(posedge clk_50M); #1 if1.start = 1'b0;
        wait_done(1, 200);
      end
      begin
        // odd parity of 0x53 is 1
        @(negedge clk_50M);
        if2.msg = 8'h53; if2.start = 1'b1;
        push_frame(2, 8'h53, 8, 1'b1, 1'b1, 1, 0, 99);
        done_q[2].push_back(48);
        @(posedge clk_50M); #1 if2.start = 1'b0;
        wait_done(2, 200);
      end
      begin
        // 7 data bits of 0xD3 (1,1,0,0,1,0,1) then two stop bits: 11 bit times
        @(negedge clk_50M);
        if3.msg = 8'hD3; if3.start = 1'b1;
        push_frame(3, 8'hD3, 7, 1'b0, 1'b0, 2, 0, 99);
        done_q[3].push_back(44);
        @(posedge clk_50M); #1 if3.start = 1'b0;
        wait_done(3, 200);
      end
      begin
        // repeat mode: done every 88 cycles with busy held high
        @(negedge clk_50M);
        if4.msg = 16'h4135; if4.start = 1'b1;
        for (int r = 0; r < 3; r++) begin
          push_frame(4, 8'h35, 8, 1'b0, 1'b0, 1, 0, 99);
          push_frame(4, 8'h41, 8, 1'b0, 1'b0, 1, 1, 99);
          done_q[4].push_back(88 * (r + 1));
        end
        @(posedge clk_50M); #1 if4.start = 1'b0;
        if4.msg = 16'hFFFF;
        for (int r = 0; r < 3; r++) wait_done(4, 150);
        @(posedge clk_50M);
        #1 rst_v[4] = 1'b1;
        @(posedge clk_50M);
        #1;
        check("rep_rst_busy", 4, int'(if4.busy), 0);
        check("rep_rst_tx", 4, int'(if4.tx), 1);
        rst_v[4] = 1'b0;
      end
    join

    repeat (10) @(negedge clk_50M);
    for (int i = 0; i < NI; i++) begin
      check("bits_left", i, exp_q[i].size(), 0);
      check("dones_left", i, done_q[i].size(), 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
